// File: rtl/i2c_pkg.sv
// i2c_pkg: types and constants shared by the I2C target receive and transmit sides.
//   ADDR_W / BYTE_W : address and byte widths on the bus
//   BIT_CNT_W       : width of the per-byte bit counter
//   i2c_state_t     : target protocol state encoding
package i2c_pkg;

   localparam int unsigned ADDR_W    = 7;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned BIT_CNT_W = 3;

   // Counter value while the last bit of a byte is being clocked in
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_DATA,
      ST_DATA_ACK,
      ST_IGNORE
   } i2c_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: 2-FF synchronizer plus one history flop for one I2C line.
//   clk, rst : system clock, synchronous active-high reset (presets to bus idle = 1)
//   pin      : raw asynchronous pin level
//   level    : synchronized level
//   rise_c   : combinational strobe, synchronized level went 0 -> 1
//   fall_c   : combinational strobe, synchronized level went 1 -> 0
module i2c_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise_c,
   output logic fall_c
);

   logic meta_q;
   logic sync_q;
   logic hist_q;

   // Synchronizer chain; preset high so an idle bus produces no edges out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         hist_q <= 1'b1;
      end else begin
         meta_q <= pin;
         sync_q <= meta_q;
         hist_q <= sync_q;
      end
   end

   assign level  = sync_q;
   assign rise_c = sync_q & ~hist_q;
   assign fall_c = ~sync_q & hist_q;

endmodule

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: receive-only I2C target. ACKs its write address and every
// following data byte; NACKs other addresses and all read requests.
//   clk, rst       : system clock, synchronous active-high reset
//   scl_in, sda_in : raw bus levels (asynchronous)
//   en             : allow ACK of a matching address (sampled at address decision)
//   sda_oe         : 1 pulls SDA low
//   data           : last received byte, held until the next byte completes
//   data_valid     : one-cycle strobe for a new byte on data
//   busy           : addressed, until STOP or repeated START
//   start_det      : one-cycle strobe on START
//   stop_det       : one-cycle strobe on STOP
module i2c_target_rx
   import i2c_pkg::*;
#(
   parameter logic [ADDR_W-1:0] DEV_ADDR = 7'h50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scl_in,
   input  logic              sda_in,
   input  logic              en,
   output logic              sda_oe,
   output logic [BYTE_W-1:0] data,
   output logic              data_valid,
   output logic              busy,
   output logic              start_det,
   output logic              stop_det
);

   logic scl_lvl, scl_rise_c, scl_fall_c;
   logic sda_lvl, sda_rise_c, sda_fall_c;

   i2c_sync_edge u_scl_sync (
      .clk    (clk),
      .rst    (rst),
      .pin    (scl_in),
      .level  (scl_lvl),
      .rise_c (scl_rise_c),
      .fall_c (scl_fall_c)
   );

   i2c_sync_edge u_sda_sync (
      .clk    (clk),
      .rst    (rst),
      .pin    (sda_in),
      .level  (sda_lvl),
      .rise_c (sda_rise_c),
      .fall_c (sda_fall_c)
   );

   i2c_state_t            state, state_nxt;
   logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
   logic [BYTE_W-1:0]     shreg, shreg_nxt;
   logic                  sda_oe_nxt;
   logic [BYTE_W-1:0]     data_nxt;
   logic                  data_valid_nxt;
   logic                  busy_nxt;
   logic                  start_det_nxt;
   logic                  stop_det_nxt;

   logic                  start_c;
   logic                  stop_c;
   logic                  last_bit_c;
   logic [BYTE_W-1:0]     shifted_c;
   logic                  addr_match_c;

   // Bus conditions and the byte as it stands after the current SCL rise
   assign start_c      = sda_fall_c & scl_lvl;
   assign stop_c       = sda_rise_c & scl_lvl;
   assign last_bit_c   = (bit_cnt == LAST_BIT);
   assign shifted_c    = {shreg[BYTE_W-2:0], sda_lvl};
   assign addr_match_c = (shifted_c[BYTE_W-1:1] == DEV_ADDR) & ~shifted_c[0] & en;

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         sda_oe     <= 1'b0;
         data       <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         start_det  <= 1'b0;
         stop_det   <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         shreg      <= shreg_nxt;
         sda_oe     <= sda_oe_nxt;
         data       <= data_nxt;
         data_valid <= data_valid_nxt;
         busy       <= busy_nxt;
         start_det  <= start_det_nxt;
         stop_det   <= stop_det_nxt;
      end
   end

   // Next state; bus conditions override bit edges seen in the same cycle
   always_comb begin
      state_nxt = state;
      if (stop_c) begin
         state_nxt = ST_IDLE;
      end else if (start_c) begin
         state_nxt = ST_ADDR;
      end else begin
         case (state)
            ST_ADDR: begin
               if (scl_rise_c && last_bit_c)
                  state_nxt = addr_match_c ? ST_ADDR_ACK : ST_IGNORE;
            end
            ST_DATA: begin
               if (scl_rise_c && last_bit_c)
                  state_nxt = ST_DATA_ACK;
            end
            // sda_oe already high means this fall ends the ACK clock
            ST_ADDR_ACK, ST_DATA_ACK: begin
               if (scl_fall_c && sda_oe)
                  state_nxt = ST_DATA;
            end
            default: ;
         endcase
      end
   end

   // Next values of the datapath and registered outputs
   always_comb begin
      bit_cnt_nxt    = bit_cnt;
      shreg_nxt      = shreg;
      sda_oe_nxt     = sda_oe;
      data_nxt       = data;
      data_valid_nxt = 1'b0;
      busy_nxt       = busy;
      start_det_nxt  = start_c;
      stop_det_nxt   = stop_c;

      if (stop_c || start_c) begin
         sda_oe_nxt  = 1'b0;
         busy_nxt    = 1'b0;
         bit_cnt_nxt = '0;
      end else begin
         case (state)
            ST_ADDR, ST_DATA: begin
               if (scl_rise_c) begin
                  shreg_nxt   = shifted_c;
                  bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                  if (last_bit_c && (state == ST_ADDR) && addr_match_c)
                     busy_nxt = 1'b1;
                  if (last_bit_c && (state == ST_DATA)) begin
                     data_nxt       = shifted_c;
                     data_valid_nxt = 1'b1;
                  end
               end
            end
            // First fall drives the ACK, second fall releases it
            ST_ADDR_ACK, ST_DATA_ACK: begin
               if (scl_fall_c)
                  sda_oe_nxt = ~sda_oe;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/i2c_target_rx.md
I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 Parameter DEV_ADDR, default 7'h50, is the 7-bit target address this block answers to.
REQ-002 clk  input  1  single system clock; all logic on posedge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 scl_in  input  1  raw SCL pin level, asynchronous to clk.
REQ-005 sda_in  input  1  raw SDA pin level, asynchronous to clk.
REQ-006 sda_oe  output  1  1 pulls SDA low (open-drain); 0 releases SDA.
REQ-007 en  input  1  1 allows ACK of a matching address; 0 NACKs all addresses.
REQ-008 data  output  8  last received data byte, MSB first on the bus; held until the next byte completes.
REQ-009 data_valid  output  1  one-cycle strobe marking a new byte on data.
REQ-010 busy  output  1  high from an address match until STOP or a repeated START.
REQ-011 start_det / stop_det  output  1 each  one-cycle strobes on START/STOP detection.

Function
REQ-012 SCL and SDA shall each pass a 2-FF synchronizer plus one history flop; edges are detected from the last two synchronized samples (3-cycle pin-to-detect latency).
REQ-013 START shall be detected as a synchronized SDA fall while synchronized SCL is high; STOP as an SDA rise while SCL is high.
REQ-014 States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-015 IDLE: sda_oe=0; START -> ADDR with bit counter cleared.
REQ-016 ADDR/DATA: shift sda on each SCL rising edge, MSB first; a 3-bit counter wraps after 8 bits.
REQ-017 After the 8th address bit: if addr[7:1]==DEV_ADDR, R/W bit==0 and en==1 -> ADDR_ACK and busy=1; otherwise -> IGNORE with sda_oe kept 0 (NACK).
REQ-018 R/W==1 (read request) shall always be NACKed; this block is receive-only.
REQ-019 ADDR_ACK/DATA_ACK: assert sda_oe on the SCL falling edge that ends bit 8; release on the SCL falling edge that ends bit 9 (ACK); then go to DATA.
REQ-020 After the 8th data bit's SCL rising edge: on the next cycle, load data and pulse data_valid for exactly 1 cycle; then go to DATA_ACK. Every data byte is ACKed; there is no backpressure.
REQ-021 START in any non-IDLE state (repeated START) shall release sda_oe the same cycle, clear busy and the counter, and go to ADDR.
REQ-022 STOP in any state shall release sda_oe, clear busy and go to IDLE; a partial byte shall be discarded without data_valid.
REQ-023 START/STOP detection shall take priority over a bit edge sampled in the same cycle.
REQ-024 en is sampled only at the address decision; deasserting en mid-transfer shall not abort the current transaction.
REQ-025 SDA changes while SCL is high, other than START/STOP, cannot occur by definition; SDA transitions while SCL is low shall be ignored.

Reset
REQ-026 While rst=1: state=IDLE, sda_oe=0, data=8'h00, data_valid=0, busy=0, start_det=0, stop_det=0, and synchronizers preset to 1 (bus idle).
REQ-027 Reset asserted mid-transfer shall release SDA on the next clk edge; after reset, the block shall ignore bus activity until the next START.

Structure
REQ-028 Shared package i2c_pkg shall hold the state enum and the I2C address-width and byte-width constants, for reuse by the transmitter side.
REQ-029 One sub-module, i2c_sync_edge, shall implement the synchronizer plus rise/fall detect per line; it is instantiated once for SCL and once for SDA.

Verification (bus model: SCL period 80 clk, as produced by the team's transmitter)
REQ-030 START, 8'hA0 (addr 0x50, W), 8'h3C, STOP -> sda_oe low during both 9th clocks; data=8'h3C with one data_valid pulse; busy falls after STOP; one start_det and one stop_det.
REQ-031 START, 8'hA2 (addr 0x51) -> no ACK; state IGNORE; a following 8'h55 produces no data_valid.
REQ-032 START, 8'hA1 (read) -> NACK; busy stays 0.
REQ-033 START, 8'hA0, 8'h11, repeated START, 8'hA0, 8'h22, STOP -> two data_valid pulses (8'h11 then 8'h22); sda_oe released at the repeated START.
REQ-034 START, 8'hA0, 4 bits of a data byte, STOP -> no data_valid; IDLE; sda_oe=0.
REQ-035 rst pulsed while sda_oe=1 during an ACK -> sda_oe=0 on the next clk; the next full transaction is ACKed normally.
